// File: rtl/rave_ooo_pkg.sv
// Shared widths and the reservation-station entry layout for the OoO core.
package rave_ooo_pkg;

  localparam int XLEN          = 32;
  localparam int ROB_SIZE      = 256;
  localparam int PHYS_REG_SIZE = 256;
  localparam int UOP_SIZE      = 16;

  localparam int ROB_W = $clog2(ROB_SIZE);
  localparam int TAG_W = $clog2(PHYS_REG_SIZE);
  localparam int UOP_W = $clog2(UOP_SIZE);

  typedef struct packed {
    logic             valid;
    logic [UOP_W-1:0] uop;
    logic [ROB_W-1:0] rob;
    logic [TAG_W-1:0] dest;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  rs1_val;
    logic [TAG_W-1:0] rs1_tag;
    logic             rs1_rdy;
    logic [XLEN-1:0]  rs2_val;
    logic [TAG_W-1:0] rs2_tag;
    logic             rs2_rdy;
  } rs_entry_t;

endpackage

// File: rtl/rs_operand_capture.sv
// Per-operand CDB wakeup: a not-ready operand whose tag matches a valid
// broadcast takes the broadcast value and becomes ready.
module rs_operand_capture
  import rave_ooo_pkg::*;
(
  input  logic             rdy_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic [XLEN-1:0]  val_i,
  input  logic             cdb_valid_i,
  input  logic [TAG_W-1:0] cdb_tag_i,
  input  logic [XLEN-1:0]  cdb_value_i,
  output logic             rdy_o,
  output logic [XLEN-1:0]  val_o
);

  logic hit_s;

  // Ready operands are never compared, so they cannot be overwritten.
  always_comb begin
    hit_s = !rdy_i && cdb_valid_i && (tag_i == cdb_tag_i);
    rdy_o = rdy_i | hit_s;
    if (hit_s) begin
      val_o = cdb_value_i;
    end else begin
      val_o = val_i;
    end
  end

endmodule

// File: rtl/arith_rsv_station.sv
// Age-ordered, compacting reservation station feeding the arithmetic FU.
// Entry 0 is always the oldest; the oldest fully-ready entry issues each cycle.
module arith_rsv_station
  import rave_ooo_pkg::*;
#(
  parameter int RS_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        disp_valid,
  output logic                        disp_ready,
  input  logic [UOP_W-1:0]            disp_uop,
  input  logic [ROB_W-1:0]            disp_rob_entry,
  input  logic [TAG_W-1:0]            disp_dest_reg,
  input  logic [XLEN-1:0]             disp_pc,
  input  logic [XLEN-1:0]             disp_rs1_val,
  input  logic [XLEN-1:0]             disp_rs2_val,
  input  logic [TAG_W-1:0]            disp_rs1_tag,
  input  logic [TAG_W-1:0]            disp_rs2_tag,
  input  logic                        disp_rs1_rdy,
  input  logic                        disp_rs2_rdy,
  input  logic                        cdb_valid,
  input  logic [TAG_W-1:0]            cdb_tag,
  input  logic [XLEN-1:0]             cdb_value,
  output logic                        issue_valid,
  output logic [UOP_W-1:0]            issue_uop,
  output logic [ROB_W-1:0]            issue_rob_entry,
  output logic [TAG_W-1:0]            issue_dest_reg,
  output logic [XLEN-1:0]             issue_rs1,
  output logic [XLEN-1:0]             issue_rs2,
  output logic [XLEN-1:0]             issue_pc,
  output logic [$clog2(RS_DEPTH):0]   occupancy
);

  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int CNT_W = IDX_W + 1;

  rs_entry_t            entries_q [RS_DEPTH];
  rs_entry_t            entries_d [RS_DEPTH];
  rs_entry_t            woke_s    [RS_DEPTH+1];
  logic                 w_rs1_rdy_s [RS_DEPTH];
  logic                 w_rs2_rdy_s [RS_DEPTH];
  logic [XLEN-1:0]      w_rs1_val_s [RS_DEPTH];
  logic [XLEN-1:0]      w_rs2_val_s [RS_DEPTH];
  rs_entry_t            new_entry_s;
  logic                 n_rs1_rdy_s, n_rs2_rdy_s;
  logic [XLEN-1:0]      n_rs1_val_s, n_rs2_val_s;
  logic [CNT_W-1:0]     occ_q, occ_d, wr_idx_s;
  logic                 accept_s, sel_found_s;
  logic [IDX_W-1:0]     sel_idx_s;

  logic                 issue_valid_q;
  logic [UOP_W-1:0]     issue_uop_q;
  logic [ROB_W-1:0]     issue_rob_q;
  logic [TAG_W-1:0]     issue_dest_q;
  logic [XLEN-1:0]      issue_rs1_q, issue_rs2_q, issue_pc_q;

  for (genvar g = 0; g < RS_DEPTH; g++) begin : g_wake
    rs_operand_capture u_cap_rs1 (
      .rdy_i(entries_q[g].rs1_rdy), .tag_i(entries_q[g].rs1_tag), .val_i(entries_q[g].rs1_val),
      .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .cdb_value_i(cdb_value),
      .rdy_o(w_rs1_rdy_s[g]), .val_o(w_rs1_val_s[g])
    );
    rs_operand_capture u_cap_rs2 (
      .rdy_i(entries_q[g].rs2_rdy), .tag_i(entries_q[g].rs2_tag), .val_i(entries_q[g].rs2_val),
      .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .cdb_value_i(cdb_value),
      .rdy_o(w_rs2_rdy_s[g]), .val_o(w_rs2_val_s[g])
    );
  end

  rs_operand_capture u_disp_rs1 (
    .rdy_i(disp_rs1_rdy), .tag_i(disp_rs1_tag), .val_i(disp_rs1_val),
    .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .cdb_value_i(cdb_value),
    .rdy_o(n_rs1_rdy_s), .val_o(n_rs1_val_s)
  );
  rs_operand_capture u_disp_rs2 (
    .rdy_i(disp_rs2_rdy), .tag_i(disp_rs2_tag), .val_i(disp_rs2_val),
    .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .cdb_value_i(cdb_value),
    .rdy_o(n_rs2_rdy_s), .val_o(n_rs2_val_s)
  );

  assign disp_ready = (occ_q < CNT_W'(RS_DEPTH));
  assign accept_s   = disp_valid && disp_ready;

  // Oldest (lowest index) entry whose both operands are ready in registered state.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (entries_q[i].valid && entries_q[i].rs1_rdy && entries_q[i].rs2_rdy) begin
        sel_found_s = 1'b1;
        sel_idx_s   = IDX_W'(i);
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Build woken entries, the incoming entry, and the compacted next state.
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      woke_s[i]         = entries_q[i];
      woke_s[i].rs1_rdy = w_rs1_rdy_s[i];
      woke_s[i].rs1_val = w_rs1_val_s[i];
      woke_s[i].rs2_rdy = w_rs2_rdy_s[i];
      woke_s[i].rs2_val = w_rs2_val_s[i];
    end
    woke_s[RS_DEPTH] = '0;

    new_entry_s         = '0;
    new_entry_s.valid   = 1'b1;
    new_entry_s.uop     = disp_uop;
    new_entry_s.rob     = disp_rob_entry;
    new_entry_s.dest    = disp_dest_reg;
    new_entry_s.pc      = disp_pc;
    new_entry_s.rs1_tag = disp_rs1_tag;
    new_entry_s.rs1_rdy = n_rs1_rdy_s;
    new_entry_s.rs1_val = n_rs1_val_s;
    new_entry_s.rs2_tag = disp_rs2_tag;
    new_entry_s.rs2_rdy = n_rs2_rdy_s;
    new_entry_s.rs2_val = n_rs2_val_s;

    // The youngest slot after compaction is where a new dispatch lands.
    wr_idx_s = occ_q - CNT_W'(sel_found_s);
    occ_d    = occ_q + CNT_W'(accept_s) - CNT_W'(sel_found_s);

    for (int i = 0; i < RS_DEPTH; i++) begin
      if (sel_found_s && (i >= int'(sel_idx_s))) begin
        entries_d[i] = woke_s[i+1];
      end else begin
        entries_d[i] = woke_s[i];
      end
      if (accept_s && (wr_idx_s == CNT_W'(i))) begin
        entries_d[i] = new_entry_s;
      end else begin
        entries_d[i] = entries_d[i];
      end
    end
  end

  // State and issue registers; reset beats flush, flush beats everything else.
  always_ff @(posedge clk) begin
    if (!rst) begin
      entries_q     <= '{default: '0};
      occ_q         <= '0;
      issue_valid_q <= 1'b0;
      issue_uop_q   <= '0;
      issue_rob_q   <= '0;
      issue_dest_q  <= '0;
      issue_rs1_q   <= '0;
      issue_rs2_q   <= '0;
      issue_pc_q    <= '0;
    end else if (flush) begin
      entries_q     <= '{default: '0};
      occ_q         <= '0;
      issue_valid_q <= 1'b0;
    end else begin
      entries_q     <= entries_d;
      occ_q         <= occ_d;
      issue_valid_q <= sel_found_s;
      if (sel_found_s) begin
        issue_uop_q  <= entries_q[sel_idx_s].uop;
        issue_rob_q  <= entries_q[sel_idx_s].rob;
        issue_dest_q <= entries_q[sel_idx_s].dest;
        issue_rs1_q  <= entries_q[sel_idx_s].rs1_val;
        issue_rs2_q  <= entries_q[sel_idx_s].rs2_val;
        issue_pc_q   <= entries_q[sel_idx_s].pc;
      end
    end
  end

  assign issue_valid     = issue_valid_q;
  assign issue_uop       = issue_uop_q;
  assign issue_rob_entry = issue_rob_q;
  assign issue_dest_reg  = issue_dest_q;
  assign issue_rs1       = issue_rs1_q;
  assign issue_rs2       = issue_rs2_q;
  assign issue_pc        = issue_pc_q;
  assign occupancy       = occ_q;

endmodule

// File: tb/tb_arith_rsv_station.sv
// Scoreboard bench: stimulus pushes expected issues, a negedge monitor checks them.
module tb_arith_rsv_station;
  import rave_ooo_pkg::*;

  typedef struct {
    logic [ROB_W-1:0] rob;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
  } exp_t;

  logic clk = 1'b0;
  logic rst, flush, disp_valid, disp_ready;
  logic [UOP_W-1:0] disp_uop;
  logic [ROB_W-1:0] disp_rob_entry;
  logic [TAG_W-1:0] disp_dest_reg, disp_rs1_tag, disp_rs2_tag, cdb_tag;
  logic [XLEN-1:0]  disp_pc, disp_rs1_val, disp_rs2_val, cdb_value;
  logic disp_rs1_rdy, disp_rs2_rdy, cdb_valid;
  logic issue_valid;
  logic [UOP_W-1:0] issue_uop;
  logic [ROB_W-1:0] issue_rob_entry;
  logic [TAG_W-1:0] issue_dest_reg;
  logic [XLEN-1:0]  issue_rs1, issue_rs2, issue_pc;
  logic [3:0] occupancy;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arith_rsv_station dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_uop(disp_uop), .disp_rob_entry(disp_rob_entry), .disp_dest_reg(disp_dest_reg),
    .disp_pc(disp_pc), .disp_rs1_val(disp_rs1_val), .disp_rs2_val(disp_rs2_val),
    .disp_rs1_tag(disp_rs1_tag), .disp_rs2_tag(disp_rs2_tag),
    .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .issue_valid(issue_valid), .issue_uop(issue_uop), .issue_rob_entry(issue_rob_entry),
    .issue_dest_reg(issue_dest_reg), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_pc(issue_pc), .occupancy(occupancy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: every issue must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && issue_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue actual_rob=0x%0h required=none", issue_rob_entry);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("issue_rob", 64'(issue_rob_entry), 64'(e.rob));
        chk("issue_rs1", 64'(issue_rs1), 64'(e.rs1));
        chk("issue_rs2", 64'(issue_rs2), 64'(e.rs2));
        chk("issue_uop", 64'(issue_uop), 64'(e.rob[UOP_W-1:0]));
        chk("issue_dest", 64'(issue_dest_reg), 64'(e.rob ^ 8'hA5));
        chk("issue_pc", 64'(issue_pc), 64'({24'h0, e.rob}) << 2);
      end
    end
  end

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] rob, input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    e.rob = rob; e.rs1 = r1; e.rs2 = r2;
    exp_q.push_back(e);
  endtask

  task automatic disp(input logic [7:0] rob,
                      input logic r1rdy, input logic [7:0] r1tag, input logic [31:0] r1val,
                      input logic r2rdy, input logic [7:0] r2tag, input logic [31:0] r2val);
    disp_valid     = 1'b1;
    disp_rob_entry = rob;
    disp_uop       = rob[UOP_W-1:0];
    disp_dest_reg  = rob ^ 8'hA5;
    disp_pc        = {24'h0, rob} << 2;
    disp_rs1_rdy = r1rdy; disp_rs1_tag = r1tag; disp_rs1_val = r1val;
    disp_rs2_rdy = r2rdy; disp_rs2_tag = r2tag; disp_rs2_val = r2val;
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    cdb_valid  = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic cdb(input logic [7:0] tag, input logic [31:0] val);
    cdb_valid = 1'b1; cdb_tag = tag; cdb_value = val;
  endtask

  initial begin
    rst = 1'b0; idle();
    disp_rob_entry = '0; disp_uop = '0; disp_dest_reg = '0; disp_pc = '0;
    disp_rs1_rdy = 1'b0; disp_rs1_tag = '0; disp_rs1_val = '0;
    disp_rs2_rdy = 1'b0; disp_rs2_tag = '0; disp_rs2_val = '0;
    cdb_tag = '0; cdb_value = '0;
    step(3);
    chk("reset_occupancy", 64'(occupancy), 64'd0);
    chk("reset_issue_valid", 64'(issue_valid), 64'd0);
    chk("reset_issue_rs1", 64'(issue_rs1), 64'd0);
    chk("reset_issue_pc", 64'(issue_pc), 64'd0);
    chk("reset_disp_ready", 64'(disp_ready), 64'd1);
    rst = 1'b1;
    step(1);

    // Basic ready dispatch
    push(8'd1, 32'd5, 32'd3);
    disp(8'd1, 1'b1, 8'd0, 32'd5, 1'b1, 8'd0, 32'd3);
    step(1); idle();
    chk("basic_occ_after_disp", 64'(occupancy), 64'd1);
    step(1);
    chk("basic_issue_valid", 64'(issue_valid), 64'd1);
    chk("basic_occ_after_issue", 64'(occupancy), 64'd0);
    step(2);

    // Wakeup via CDB on a stored entry
    disp(8'd2, 1'b0, 8'd17, 32'd0, 1'b1, 8'd0, 32'd7);
    step(1); idle();
    step(3);
    chk("wait_no_issue", 64'(issue_valid), 64'd0);
    push(8'd2, 32'hDEAD, 32'd7);
    cdb(8'd17, 32'hDEAD);
    step(1); idle();
    chk("wake_not_yet_issued", 64'(issue_valid), 64'd0);
    step(1);
    chk("wake_issue_valid", 64'(issue_valid), 64'd1);
    step(2);

    // Dispatch-cycle wakeup
    push(8'd3, 32'd1, 32'd42);
    disp(8'd3, 1'b1, 8'd0, 32'd1, 1'b0, 8'd9, 32'd0);
    cdb(8'd9, 32'd42);
    step(1); idle();
    step(1);
    chk("dispwake_issue_valid", 64'(issue_valid), 64'd1);
    step(2);

    // Age order: A waits, B then C issue, then A after wakeup
    push(8'd5, 32'd10, 32'd11);
    push(8'd6, 32'd12, 32'd13);
    disp(8'd4, 1'b0, 8'd20, 32'd0, 1'b1, 8'd0, 32'd2); step(1);
    disp(8'd5, 1'b1, 8'd0, 32'd10, 1'b1, 8'd0, 32'd11); step(1);
    disp(8'd6, 1'b1, 8'd0, 32'd12, 1'b1, 8'd0, 32'd13); step(1);
    idle(); step(3);
    chk("order_occ_A_left", 64'(occupancy), 64'd1);
    push(8'd4, 32'h55, 32'd2);
    cdb(8'd20, 32'h55);
    step(1); idle(); step(3);
    chk("order_occ_empty", 64'(occupancy), 64'd0);

    // Fill to capacity with nothing ready
    for (int i = 0; i < 8; i++) begin
      disp(8'(10 + i), 1'b0, 8'(30 + i), 32'd0, 1'b1, 8'd0, 32'(i));
      step(1);
    end
    idle();
    chk("full_occ", 64'(occupancy), 64'd8);
    chk("full_disp_ready", 64'(disp_ready), 64'd0);
    disp(8'd99, 1'b1, 8'd0, 32'd1, 1'b1, 8'd0, 32'd1);
    step(1); idle();
    chk("full_ninth_ignored", 64'(occupancy), 64'd8);
    push(8'd13, 32'h77, 32'd3);
    cdb(8'd33, 32'h77);
    step(1); idle();
    chk("full_ready_still_0", 64'(disp_ready), 64'd0);
    step(1);
    chk("full_occ_7", 64'(occupancy), 64'd7);
    chk("full_ready_back", 64'(disp_ready), 64'd1);
    step(2);

    // Reset mid-operation, then flush with 5 entries and a competing dispatch
    rst = 1'b0; step(1); rst = 1'b1;
    chk("midreset_occ", 64'(occupancy), 64'd0);
    for (int i = 0; i < 5; i++) begin
      disp(8'(40 + i), 1'b0, 8'(40 + i), 32'd0, 1'b1, 8'd0, 32'd0);
      step(1);
    end
    idle();
    chk("preflush_occ", 64'(occupancy), 64'd5);
    flush = 1'b1;
    disp(8'd88, 1'b1, 8'd0, 32'd8, 1'b1, 8'd0, 32'd8);
    step(1); idle();
    chk("flush_occ", 64'(occupancy), 64'd0);
    chk("flush_issue_valid", 64'(issue_valid), 64'd0);
    for (int i = 0; i < 5; i++) begin
      cdb(8'(40 + i), 32'h1234);
      step(1);
    end
    idle(); step(3);
    chk("postflush_occ", 64'(occupancy), 64'd0);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
